// File: rtl/bkp_pkg.sv
// rtl/bkp_pkg.sv - shared FSM state type and constants for the bkp UART transmitter
package bkp_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} bkp_state_e;
  localparam int BKP_FRAME_BITS  = 10;
  localparam int BKP_DEF_CLK_DIV = 868;
endpackage

// File: rtl/bkp_sync_fifo.sv
// rtl/bkp_sync_fifo.sv - synchronous word FIFO with registered read data and occupancy count
module bkp_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_data <= mem[rd_ptr];
      end
      count <= count + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, rd_en};
    end
  end

  // Storage needs no reset; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end
endmodule

// File: rtl/bkp_uart_tx.sv
// rtl/bkp_uart_tx.sv - buffered 8N1 serialiser for MBKP words, lowest byte first
module bkp_uart_tx
  import bkp_pkg::*;
#(
  parameter int bkp_data_with = 8,
  parameter int CLK_DIV       = BKP_DEF_CLK_DIV,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     Bkp_Ready_i,
  input  logic [bkp_data_with-1:0] Bkp_Data_i,
  output logic                     Bkp_Busy_o,
  output logic                     uart_tx_o,
  output logic                     tx_active_o,
  output logic                     overflow_o
);
  localparam int NB = bkp_data_with / 8;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
  localparam logic [1:0]    LAST_BYTE = 2'(NB - 1);

  logic [CW-1:0]            count;
  logic [bkp_data_with-1:0] rd_data;
  logic                     wr_en;
  logic                     pop;
  bkp_state_e               state;
  logic [BW-1:0]            baud_cnt;
  logic                     bit_end;
  logic [2:0]               bit_cnt;
  logic [1:0]               byte_idx;
  logic [bkp_data_with-1:0] word_reg;
  logic [7:0]               shift;
  logic                     load_pend;

  assign Bkp_Busy_o  = (count == FULL);
  assign wr_en       = Bkp_Ready_i && !Bkp_Busy_o;
  assign pop         = (state == ST_IDLE) && (count != '0);
  assign tx_active_o = (state != ST_IDLE);
  assign bit_end     = (baud_cnt == BAUD_LAST);

  bkp_sync_fifo #(.WIDTH(bkp_data_with), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (Bkp_Data_i),
    .rd_en   (pop),
    .rd_data (rd_data),
    .count   (count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      byte_idx   <= '0;
      word_reg   <= '0;
      shift      <= '0;
      load_pend  <= 1'b0;
      uart_tx_o  <= 1'b1;
      overflow_o <= 1'b0;
    end else begin
      if (Bkp_Ready_i && Bkp_Busy_o) overflow_o <= 1'b1;

      // FIFO read data lands one cycle after the pop, during the first start-bit cycle.
      if (load_pend) begin
        word_reg  <= rd_data;
        shift     <= rd_data[7:0];
        load_pend <= 1'b0;
      end

      if (state != ST_IDLE) baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;

      case (state)
        ST_IDLE: begin
          if (count != '0) begin
            state     <= ST_START;
            uart_tx_o <= 1'b0;
            byte_idx  <= '0;
            load_pend <= 1'b1;
            baud_cnt  <= '0;
          end
        end
        ST_START: begin
          if (bit_end) begin
            state     <= ST_DATA;
            uart_tx_o <= shift[0];
            shift     <= shift >> 1;
            bit_cnt   <= '0;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            if (bit_cnt == 3'd7) begin
              state     <= ST_STOP;
              uart_tx_o <= 1'b1;
            end else begin
              bit_cnt   <= bit_cnt + 3'd1;
              uart_tx_o <= shift[0];
              shift     <= shift >> 1;
            end
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            if (byte_idx != LAST_BYTE) begin
              byte_idx  <= byte_idx + 2'd1;
              shift     <= 8'(word_reg >> {byte_idx + 2'd1, 3'b000});
              uart_tx_o <= 1'b0;
              state     <= ST_START;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bkp_uart_tx.sv
// tb/tb_bkp_uart_tx.sv - randomized bench for bkp_uart_tx against a frame-level reference model
module tb_bkp_uart_tx;
  import bkp_pkg::*;

  localparam int CD    = 4;
  localparam int FRAME = BKP_FRAME_BITS * CD;

  typedef struct {
    int         start;
    logic [7:0] b;
    logic       stop;
  } rx_t;

  logic             clk = 1'b0;
  logic [1:0]       rst_n, ready, busy, line, active, ovf;
  logic [1:0][15:0] data;
  int               cyc = 0;
  int               n_pass = 0;
  int               n_total = 0;
  rx_t              rx0[$], rx1[$];
  int               mcnt [2];
  bit               mbusy [2];
  rx_t              mrec [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bkp_uart_tx #(.bkp_data_with(8), .CLK_DIV(CD), .FIFO_DEPTH(4)) dut8 (
    .clk(clk), .rst_n(rst_n[0]), .Bkp_Ready_i(ready[0]), .Bkp_Data_i(data[0][7:0]),
    .Bkp_Busy_o(busy[0]), .uart_tx_o(line[0]), .tx_active_o(active[0]), .overflow_o(ovf[0]));

  bkp_uart_tx #(.bkp_data_with(16), .CLK_DIV(CD), .FIFO_DEPTH(4)) dut16 (
    .clk(clk), .rst_n(rst_n[1]), .Bkp_Ready_i(ready[1]), .Bkp_Data_i(data[1]),
    .Bkp_Busy_o(busy[1]), .uart_tx_o(line[1]), .tx_active_o(active[1]), .overflow_o(ovf[1]));

  // Line decoder: finds start bits and samples each bit in its middle.
  initial forever begin
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      if (!mbusy[u]) begin
        if (line[u] === 1'b0) begin
          mbusy[u] = 1'b1;
          mcnt[u] = 0;
          mrec[u].start = cyc;
        end
      end else begin
        mcnt[u]++;
        if (mcnt[u] >= CD && mcnt[u] < 9 * CD && mcnt[u] % CD == CD / 2)
          mrec[u].b[mcnt[u] / CD - 1] = line[u];
        if (mcnt[u] == 9 * CD + CD / 2) begin
          mrec[u].stop = line[u];
          if (u == 0) rx0.push_back(mrec[u]);
          else rx1.push_back(mrec[u]);
        end
        if (mcnt[u] == FRAME - 1) mbusy[u] = 1'b0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Expected line level k cycles after the start bit of a word.
  function automatic logic exp_line(logic [15:0] w, int nb, int k);
    int pos;
    if (k < 0 || k >= nb * FRAME) return 1'b1;
    pos = (k % FRAME) / CD;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return w[8 * (k / FRAME) + pos - 1];
  endfunction

  function automatic logic [127:0] exp_lvec(logic [15:0] w, int nb);
    logic [127:0] v;
    v = '0;
    for (int k = 0; k < nb * FRAME + 2; k++) v[k] = exp_line(w, nb, k - 1);
    return v;
  endfunction

  function automatic logic [127:0] exp_avec(int nb);
    logic [127:0] v;
    v = '0;
    for (int k = 1; k <= nb * FRAME; k++) v[k] = 1'b1;
    return v;
  endfunction

  // Strobe one word and record line/active from the cycle after the strobe.
  task automatic capture(input int u, input int nb, input logic [15:0] w,
                         output int t, output logic [127:0] gl, output logic [127:0] ga);
    gl = '0;
    ga = '0;
    @(negedge clk);
    t = cyc;
    ready[u] = 1'b1;
    data[u] = w;
    for (int k = 0; k < nb * FRAME + 2; k++) begin
      @(negedge clk);
      if (k == 0) ready[u] = 1'b0;
      gl[k] = line[u];
      ga[k] = active[u];
    end
  endtask

  task automatic drain(input int u, output int busy_fall);
    int idle_run;
    idle_run = 0;
    busy_fall = -1;
    for (int k = 0; k < 400 && idle_run < 3; k++) begin
      @(negedge clk);
      if (busy_fall < 0 && busy[u] === 1'b0) busy_fall = cyc;
      idle_run = (active[u] === 1'b0) ? idle_run + 1 : 0;
    end
  endtask

  task automatic test_reset();
    rst_n = 2'b00;
    ready = '0;
    data = '0;
    repeat (3) @(negedge clk);
    n_total++; if (line[0] !== 1'b1) $display("FAIL reset_line: got %b exp 1", line[0]); else n_pass++;
    n_total++; if (busy[0] !== 1'b0) $display("FAIL reset_busy: got %b exp 0", busy[0]); else n_pass++;
    n_total++; if (ovf[0] !== 1'b0) $display("FAIL reset_overflow: got %b exp 0", ovf[0]); else n_pass++;
    n_total++; if (active[0] !== 1'b0) $display("FAIL reset_active: got %b exp 0", active[0]); else n_pass++;
    n_total++; if (line[1] !== 1'b1) $display("FAIL reset_line16: got %b exp 1", line[1]); else n_pass++;
    rst_n = 2'b11;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_byte();
    logic [127:0] gl, ga;
    logic [7:0] b;
    int t;
    for (int i = 0; i < 4; i++) begin
      b = (i == 0) ? 8'hA5 : 8'($urandom);
      rx0.delete();
      capture(0, 1, {8'h00, b}, t, gl, ga);
      n_total++; if (gl !== exp_lvec({8'h00, b}, 1)) $display("FAIL single_line[%0h]: got %h exp %h", b, gl, exp_lvec({8'h00, b}, 1)); else n_pass++;
      n_total++; if (ga !== exp_avec(1)) $display("FAIL single_active[%0h]: got %h exp %h", b, ga, exp_avec(1)); else n_pass++;
      n_total++;
      if (rx0.size() != 1 || rx0[0].b !== b || rx0[0].stop !== 1'b1 || rx0[0].start != t + 2)
        $display("FAIL single_decode[%0h]: got %0d frames first %h start %0d exp %h start %0d", b, rx0.size(),
                 (rx0.size() > 0) ? rx0[0].b : 8'hxx, (rx0.size() > 0) ? rx0[0].start : -1, b, t + 2);
      else n_pass++;
    end
  endtask

  task automatic test_multi_byte();
    logic [127:0] gl, ga;
    logic [15:0] w;
    int t;
    for (int i = 0; i < 3; i++) begin
      w = (i == 0) ? 16'h1234 : 16'($urandom);
      rx1.delete();
      capture(1, 2, w, t, gl, ga);
      n_total++; if (gl !== exp_lvec(w, 2)) $display("FAIL multi_line[%0h]: got %h exp %h", w, gl, exp_lvec(w, 2)); else n_pass++;
      n_total++; if (ga !== exp_avec(2)) $display("FAIL multi_active[%0h]: got %h exp %h", w, ga, exp_avec(2)); else n_pass++;
      n_total++;
      if (rx1.size() != 2 || {rx1[1].b, rx1[0].b} !== w || rx1[1].start != t + 2 + FRAME)
        $display("FAIL multi_decode[%0h]: got %0d frames second start %0d exp 2 frames start %0d", w, rx1.size(),
                 (rx1.size() > 1) ? rx1[1].start : -1, t + 2 + FRAME);
      else n_pass++;
    end
  endtask

  task automatic test_fill_overflow();
    logic [7:0] w [6];
    logic [7:0] exp_q[$];
    int mcount, t0, fall;
    bit exp_ovf;
    mcount = 0;
    exp_ovf = 1'b0;
    for (int i = 0; i < 6; i++) w[i] = 8'($urandom);
    rx0.delete();
    @(negedge clk);
    t0 = cyc;
    ready[0] = 1'b1;
    data[0] = {8'h00, w[0]};
    exp_q.push_back(w[0]);
    @(negedge clk);
    ready[0] = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 1; i <= 5; i++) begin
      n_total++; if (busy[0] !== (mcount == 4)) $display("FAIL fill_busy[%0d]: got %b exp %b", i, busy[0], mcount == 4); else n_pass++;
      n_total++; if (ovf[0] !== exp_ovf) $display("FAIL fill_overflow[%0d]: got %b exp %b", i, ovf[0], exp_ovf); else n_pass++;
      ready[0] = 1'b1;
      data[0] = {8'h00, w[i]};
      if (mcount < 4) begin
        exp_q.push_back(w[i]);
        mcount++;
      end else exp_ovf = 1'b1;
      @(negedge clk);
    end
    ready[0] = 1'b0;
    n_total++; if (busy[0] !== 1'b1) $display("FAIL fill_busy_full: got %b exp 1", busy[0]); else n_pass++;
    n_total++; if (ovf[0] !== exp_ovf) $display("FAIL fill_overflow_set: got %b exp %b", ovf[0], exp_ovf); else n_pass++;
    drain(0, fall);
    n_total++; if (fall != t0 + 3 + FRAME) $display("FAIL fill_busy_drop: got cycle %0d exp %0d", fall, t0 + 3 + FRAME); else n_pass++;
    n_total++; if (rx0.size() != exp_q.size()) $display("FAIL fill_frame_count: got %0d exp %0d", rx0.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < rx0.size() && i < exp_q.size(); i++) begin
      n_total++;
      if (rx0[i].b !== exp_q[i] || rx0[i].start != t0 + 2 + i * (FRAME + 1))
        $display("FAIL fill_word[%0d]: got %h at %0d exp %h at %0d", i, rx0[i].b, rx0[i].start, exp_q[i], t0 + 2 + i * (FRAME + 1));
      else n_pass++;
    end
    n_total++; if (ovf[0] !== 1'b1) $display("FAIL fill_overflow_sticky: got %b exp 1", ovf[0]); else n_pass++;
    rst_n[0] = 1'b0;
    @(negedge clk);
    rst_n[0] = 1'b1;
    @(negedge clk);
    n_total++; if (ovf[0] !== 1'b0) $display("FAIL fill_overflow_clear: got %b exp 0", ovf[0]); else n_pass++;
  endtask

  task automatic test_simultaneous();
    logic [7:0] w [3];
    int t0, fall;
    for (int i = 0; i < 3; i++) w[i] = 8'($urandom);
    rx0.delete();
    @(negedge clk);
    t0 = cyc;
    ready[0] = 1'b1;
    data[0] = {8'h00, w[0]};
    @(negedge clk);
    data[0] = {8'h00, w[1]};
    @(negedge clk);
    ready[0] = 1'b0;
    while (cyc < t0 + 2 + FRAME) @(negedge clk);
    n_total++; if (active[0] !== 1'b0) $display("FAIL simul_idle_gap: got %b exp 0", active[0]); else n_pass++;
    ready[0] = 1'b1;
    data[0] = {8'h00, w[2]};
    @(negedge clk);
    ready[0] = 1'b0;
    n_total++; if (busy[0] !== 1'b0 || active[0] !== 1'b1) $display("FAIL simul_after_pop: got busy %b active %b exp 0 1", busy[0], active[0]); else n_pass++;
    drain(0, fall);
    n_total++; if (rx0.size() != 3) $display("FAIL simul_frame_count: got %0d exp 3", rx0.size()); else n_pass++;
    for (int i = 0; i < rx0.size() && i < 3; i++) begin
      n_total++;
      if (rx0[i].b !== w[i] || rx0[i].start != t0 + 2 + i * (FRAME + 1))
        $display("FAIL simul_word[%0d]: got %h at %0d exp %h at %0d", i, rx0[i].b, rx0[i].start, w[i], t0 + 2 + i * (FRAME + 1));
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [127:0] gl, ga;
    logic [15:0] w, w2;
    int t0, t;
    bit low_seen;
    w = 16'($urandom);
    w2 = 16'($urandom);
    @(negedge clk);
    t0 = cyc;
    ready[1] = 1'b1;
    data[1] = w;
    @(negedge clk);
    data[1] = w2;
    @(negedge clk);
    ready[1] = 1'b0;
    while (cyc < t0 + 19) @(negedge clk);
    n_total++; if (line[1] !== exp_line(w, 2, 17)) $display("FAIL midrst_bit3: got %b exp %b", line[1], exp_line(w, 2, 17)); else n_pass++;
    rst_n[1] = 1'b0;
    @(negedge clk);
    rst_n[1] = 1'b1;
    n_total++; if (line[1] !== 1'b1 || active[1] !== 1'b0 || busy[1] !== 1'b0)
      $display("FAIL midrst_after: got line %b active %b busy %b exp 1 0 0", line[1], active[1], busy[1]); else n_pass++;
    low_seen = 1'b0;
    repeat (45) begin
      @(negedge clk);
      if (line[1] !== 1'b1 || active[1] !== 1'b0) low_seen = 1'b1;
    end
    n_total++; if (low_seen) $display("FAIL midrst_fifo_empty: got activity after reset exp none"); else n_pass++;
    rx1.delete();
    capture(1, 2, w2 ^ 16'h5a5a, t, gl, ga);
    n_total++; if (gl !== exp_lvec(w2 ^ 16'h5a5a, 2)) $display("FAIL midrst_resend: got %h exp %h", gl, exp_lvec(w2 ^ 16'h5a5a, 2)); else n_pass++;
    n_total++; if (ga !== exp_avec(2)) $display("FAIL midrst_resend_active: got %h exp %h", ga, exp_avec(2)); else n_pass++;
  endtask

  initial begin
    rst_n = '0;
    ready = '0;
    data = '0;
    test_reset();
    test_single_byte();
    test_multi_byte();
    test_fill_overflow();
    test_simultaneous();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/bkp_uart_tx.md
# bkp_uart_tx

Serial transmitter on the MBKP side of the bk interface configuration stage. It accepts `Bkp_Ready_i`/`Bkp_Data_i` words through a small FIFO and back-pressures the sender with `Bkp_Busy_o`. Each word is serialised as one or more 8N1 UART frames on `uart_tx_o`. It gives host-written bkt data a physical path off-chip.

## Interface
Parameters:
- `bkp_data_with`, 8: width of `Bkp_Data_i`. Must be a multiple of 8, range 8..32. `NB = bkp_data_with/8` bytes per word.
- `CLK_DIV`, 868: clock cycles per UART bit (100 MHz / 115200). Minimum 2.
- `FIFO_DEPTH`, 4: words buffered. Power of two, range 2..16.

Ports:
- `clk`  in  1  single clock domain.
- `rst_n`  in  1  reset, synchronous, active-low.
- `Bkp_Ready_i`  in  1  one-cycle write strobe from the MBKP source.
- `Bkp_Data_i`  in  `bkp_data_with`  word captured when `Bkp_Ready_i`=1.
- `Bkp_Busy_o`  out  1  FIFO full; the source must not strobe.
- `uart_tx_o`  out  1  serial line, idle high.
- `tx_active_o`  out  1  FSM is not in IDLE.
- `overflow_o`  out  1  sticky flag: a strobe was dropped.

## Operation
- FIFO:
  - Write on `Bkp_Ready_i` when `count < FIFO_DEPTH`.
  - Pop when the FSM loads a word.
  - Write and pop in the same cycle: `count` is unchanged and both take effect.
  - Strobe while `count == FIFO_DEPTH`: word dropped and `overflow_o` set to 1. This applies even if a pop occurs in the same cycle. `overflow_o` clears only on reset.
- `Bkp_Busy_o = (count == FIFO_DEPTH)`, decoded from the registered count with no extra latency.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE → START when `count != 0`. Pop the head word into a word register, set `byte_idx=0`, load the shift register with byte 0 (`[7:0]`).
  - START: `uart_tx_o=0` for `CLK_DIV` cycles, then → DATA.
  - DATA: 8 bits, LSB first, each held `CLK_DIV` cycles. `bit_cnt` counts 0..7. After bit 7 → STOP.
  - STOP: `uart_tx_o=1` for `CLK_DIV` cycles.
    - If `byte_idx < NB-1`: increment `byte_idx`, load the next byte (byte k = `[8k+7:8k]`, lowest byte first), → START.
    - Otherwise → IDLE.
- Baud counter: runs 0..`CLK_DIV-1` inside START/DATA/STOP and is held at 0 in IDLE. A bit boundary occurs at `CLK_DIV-1`.
- `uart_tx_o` is registered.
- `tx_active_o` = state != IDLE.

## Timing
- Reset values: `uart_tx_o=1`, `Bkp_Busy_o=0`, `tx_active_o=0`, `overflow_o=0`. FIFO is empty and FSM is in IDLE. Reset mid-frame aborts immediately; the line returns high on the cycle after `rst_n` is sampled low.
- Latency:
  - Strobe at cycle t into an empty FIFO with the FSM in IDLE: the write is visible at t+1.
  - The FSM pops at t+1.
  - `uart_tx_o` falls at t+2.
- Frame: exactly `10*CLK_DIV` cycles.
- Word: `NB*10*CLK_DIV` cycles, with multi-byte frames back-to-back and no gap.
- Between words: exactly one IDLE cycle, so the next start bit begins 1 cycle after the previous stop bit ends.
- Busy: a write at cycle t that fills the FIFO raises `Bkp_Busy_o` at t+1. Busy drops the cycle after the pop that frees a slot.
- Back-pressure: the upstream source samples `Bkp_Busy_o` one cycle before its registered strobe. With at most one strobe per bkt access, no data is lost.

## Structure
- Shared package (`bkp_pkg`):
  - FSM state enum.
  - Constants `BKP_FRAME_BITS=10` and `BKP_DEF_CLK_DIV=868`.
- One sub-module: `bkp_sync_fifo`.
  - Parameters: width, depth.
  - Ports: `wr_en`, `wr_data`, `rd_en`, `rd_data`, `count`.
  - Behaviour: synchronous active-low reset, registered read data valid the cycle after `rd_en`.
  - The FSM accounts for this one-cycle read latency when loading the shift register.
- The top holds the FSM, baud counter, shift register and flags.

## Test plan
- **Reset:** `CLK_DIV=4`, 8-bit. Hold `rst_n` low 3 cycles. Expect `uart_tx_o=1`, `Bkp_Busy_o=0`, `overflow_o=0`, `tx_active_o=0`.
- **Single byte:** `CLK_DIV=4`. Strobe `0xA5` at t. Expect:
  - `uart_tx_o` low at t+2 for 4 cycles.
  - Bits 1,0,1,0,0,1,0,1 at 4 cycles each.
  - Stop high 4 cycles.
  - `tx_active_o` falls at t+42.
- **Multi-byte:** `bkp_data_with=16`. Strobe `0x1234`. Expect frames `0x34` then `0x12`, with no idle cycle between them, totalling 80 cycles.
- **Fill and overflow:** `FIFO_DEPTH=4`. Strobe 5 words on consecutive cycles while a frame is in progress. Expect:
  - `Bkp_Busy_o`=1 after the 4th accepted word.
  - The 5th word is dropped and `overflow_o` sticks at 1.
  - The transmitted sequence omits the 5th word.
- **Simultaneous write/pop:** FIFO at `count=1`, FSM in IDLE. Strobe on the same cycle the FSM pops. Expect `count` stays 1 and both words are sent in order with a 1-cycle inter-word gap.
- **Reset mid-frame:** Assert `rst_n` low during DATA bit 3. Expect `uart_tx_o=1` the next cycle and the FIFO empty. A new strobe after reset is sent correctly.
